// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit: the bypass-select
// encodings driven onto fwd_sel and the multiplier tracker state encoding.
package hazard_pkg;

    // Bypass source selected for an EX operand
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_MEMWB = 2'b01,
        FWD_EXMEM = 2'b10,
        FWD_MUL   = 2'b11
    } fwd_sel_e;

    // Multiplier tracker states
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_e;

    // Width of the multiplier latency down-counter (MUL_LAT up to 15)
    localparam int CNT_W = 4;

endpackage

// File: rtl/hazard_forward_unit_mul_tracker.sv
// Multiplier tracker: follows a single multi-cycle multiply from issue to
// completion, holding its destination so dependents can be stalled and
// (when MUL_FWD_EN is defined) released one cycle early to pick up the
// result through the bypass network.
module mul_tracker
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MUL_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issueValid,
    input  logic [REG_AW-1:0] issueAddr,
    output logic              mulBusy,
    output logic              mulDone,
    output logic [REG_AW-1:0] mulWrAddr,
    output logic              notReleased
);

    // Counter value on issue: done appears MUL_LAT cycles after the issue cycle
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MUL_LAT - 1);

    mul_state_e         stateReg, stateNext;
    logic [CNT_W-1:0]   countReg, countNext;
    logic [REG_AW-1:0]  destReg, destNext;
    logic               issue;

    // State, counter and captured destination registers
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg <= IDLE;
            countReg <= '0;
            destReg  <= '0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            destReg  <= destNext;
        end
    end

    // Next-state logic: issue from IDLE or in the completing cycle of BUSY
    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        destNext  = destReg;
        mulDone   = (stateReg == BUSY) && (countReg == '0);
        issue     = issueValid && ((stateReg == IDLE) || mulDone);
        case (stateReg)
            IDLE: begin
                if (issue) begin
                    stateNext = BUSY;
                    countNext = LOAD_VAL;
                    destNext  = issueAddr;
                end
            end
            BUSY: begin
                if (issue) begin
                    countNext = LOAD_VAL;
                    destNext  = issueAddr;
                end else if (mulDone) begin
                    stateNext = IDLE;
                end else begin
                    countNext = countReg - 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign mulBusy   = (stateReg == BUSY);
    assign mulWrAddr = destReg;

`ifdef MUL_FWD_EN
    // Dependents may enter EX in the done cycle, so release at counter=1
    assign notReleased = (stateReg == BUSY) && (countReg > CNT_W'(1));
`else
    // Dependents must read the register file, so hold until the done cycle
    assign notReleased = (stateReg == BUSY) && (countReg != '0);
`endif

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a pipeline with a
// multi-cycle multiplier. Per-operand bypass select is combinational;
// stall covers load-use, RAW on an in-flight multiply and the
// single-multiplier structural hazard.
// Optional macro MUL_FWD_EN: forward the multiplier result directly into
// EX in its completion cycle (fwd_sel=11) and release dependents a cycle early.
// Legal parameter ranges: NUM_RD 1..4, MUL_LAT 2..15.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int NUM_RD  = 2,
    parameter int MUL_LAT = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic                     id_is_mul,
    input  logic [NUM_RD*REG_AW-1:0] id_src,
    input  logic [NUM_RD*REG_AW-1:0] ex_src,
    input  logic                     ex_valid,
    input  logic                     ex_is_load,
    input  logic                     ex_is_mul,
    input  logic [REG_AW-1:0]        ex_wr_addr,
    input  logic                     exmem_wr_en,
    input  logic [REG_AW-1:0]        exmem_wr_addr,
    input  logic                     memwb_wr_en,
    input  logic [REG_AW-1:0]        memwb_wr_addr,
    output logic [2*NUM_RD-1:0]      fwd_sel,
    output logic                     stall,
    output logic                     mul_busy,
    output logic                     mul_done,
    output logic [REG_AW-1:0]        mul_wr_addr
);

    logic              notReleased;
    logic              mulIssue;
    logic [NUM_RD-1:0] loadHit;
    logic [NUM_RD-1:0] mulRawHit;

    assign mulIssue = ex_valid && ex_is_mul;

    mul_tracker #(
        .REG_AW  (REG_AW),
        .MUL_LAT (MUL_LAT)
    ) uTracker (
        .clk         (clk),
        .rst         (rst),
        .issueValid  (mulIssue),
        .issueAddr   (ex_wr_addr),
        .mulBusy     (mul_busy),
        .mulDone     (mul_done),
        .mulWrAddr   (mul_wr_addr),
        .notReleased (notReleased)
    );

    for (genvar gi = 0; gi < NUM_RD; gi++) begin : gOperand
        logic [REG_AW-1:0] exSrc;
        logic [REG_AW-1:0] idSrc;
        logic              mulHit;
        fwd_sel_e          sel;

        assign exSrc = ex_src[gi*REG_AW +: REG_AW];
        assign idSrc = id_src[gi*REG_AW +: REG_AW];

`ifdef MUL_FWD_EN
        assign mulHit = mul_done && (mul_wr_addr == exSrc);
`else
        assign mulHit = 1'b0;
`endif

        // Bypass priority: multiplier > EX/MEM > MEM/WB > register file; r0 never bypassed
        always_comb begin
            sel = FWD_RF;
            if (exSrc != '0) begin
                if (mulHit) begin
                    sel = FWD_MUL;
                end else if (exmem_wr_en && (exmem_wr_addr == exSrc)) begin
                    sel = FWD_EXMEM;
                end else if (memwb_wr_en && (memwb_wr_addr == exSrc)) begin
                    sel = FWD_MEMWB;
                end
            end
        end

        assign fwd_sel[2*gi +: 2] = sel;
        assign loadHit[gi]        = (ex_wr_addr != '0) && (idSrc == ex_wr_addr);
        assign mulRawHit[gi]      = (idSrc != '0) && (idSrc == mul_wr_addr);
    end

    assign stall = id_valid &&
                   ((ex_valid && ex_is_load && (|loadHit)) ||
                    (notReleased && ((|mulRawHit) || id_is_mul)));

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed scoreboard bench for hazard_forward_unit (REG_AW=5, NUM_RD=2, MUL_LAT=4).
// Expectations adapt to MUL_FWD_EN so the bench serves both builds.
module tb_hazard_forward_unit;

    localparam int RAW = 5;
    localparam int NRD = 2;
    localparam int LAT = 4;
`ifdef MUL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic               clk;
    logic               rst;
    logic               id_valid, id_is_mul;
    logic [NRD*RAW-1:0] id_src, ex_src;
    logic               ex_valid, ex_is_load, ex_is_mul;
    logic [RAW-1:0]     ex_wr_addr;
    logic               exmem_wr_en, memwb_wr_en;
    logic [RAW-1:0]     exmem_wr_addr, memwb_wr_addr;
    logic [2*NRD-1:0]   fwd_sel;
    logic               stall, mul_busy, mul_done;
    logic [RAW-1:0]     mul_wr_addr;

    hazard_forward_unit #(.REG_AW(RAW), .NUM_RD(NRD), .MUL_LAT(LAT)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_is_mul     (id_is_mul),
        .id_src        (id_src),
        .ex_src        (ex_src),
        .ex_valid      (ex_valid),
        .ex_is_load    (ex_is_load),
        .ex_is_mul     (ex_is_mul),
        .ex_wr_addr    (ex_wr_addr),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_wr_addr (exmem_wr_addr),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_wr_addr (memwb_wr_addr),
        .fwd_sel       (fwd_sel),
        .stall         (stall),
        .mul_busy      (mul_busy),
        .mul_done      (mul_done),
        .mul_wr_addr   (mul_wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [3:0] fwd;
        logic       stall;
        logic       busy;
        logic       done;
        logic       chkAddr;
        logic [4:0] addr;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;
    exp_t e;
    logic ok;

    // Monitor: compare every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e  = q.pop_front();
            ok = (fwd_sel === e.fwd) && (stall === e.stall) &&
                 (mul_busy === e.busy) && (mul_done === e.done) &&
                 (!e.chkAddr || (mul_wr_addr === e.addr));
            checks++;
            if (ok) begin
                passed++;
                $display("ok   %-22s cyc=%0d fwd=%b stall=%b busy=%b done=%b addr=%0d",
                         e.name, cyc, fwd_sel, stall, mul_busy, mul_done, mul_wr_addr);
            end else begin
                $display("FAIL %s cyc=%0d got fwd=%b stall=%b busy=%b done=%b addr=%0d want fwd=%b stall=%b busy=%b done=%b addr=%0d(chk=%b)",
                         e.name, cyc, fwd_sel, stall, mul_busy, mul_done, mul_wr_addr,
                         e.fwd, e.stall, e.busy, e.done, e.addr, e.chkAddr);
            end
        end
    end

    task automatic expectOut(input string name, input logic [3:0] f, input logic s,
                             input logic b, input logic d, input logic ca, input logic [4:0] a);
        exp_t x;
        x.cyc = cyc; x.name = name; x.fwd = f; x.stall = s;
        x.busy = b; x.done = d; x.chkAddr = ca; x.addr = a;
        q.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        id_valid = 0; id_is_mul = 0; id_src = '0; ex_src = '0;
        ex_valid = 0; ex_is_load = 0; ex_is_mul = 0; ex_wr_addr = '0;
        exmem_wr_en = 0; exmem_wr_addr = '0; memwb_wr_en = 0; memwb_wr_addr = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clearIn();

        // Reset state
        step(); rst = 1'b0;
        expectOut("reset", 4'b0000, 0, 0, 0, 1, 5'd0);

        // Forwarding: EX/MEM beats MEM/WB on the same register
        step();
        exmem_wr_en = 1; exmem_wr_addr = 5; memwb_wr_en = 1; memwb_wr_addr = 5;
        ex_src = {5'd3, 5'd5};
        expectOut("fwd_exmem_over_memwb", 4'b0010, 0, 0, 0, 0, 5'd0);

        step();
        exmem_wr_addr = 3; memwb_wr_addr = 5; ex_src = {5'd3, 5'd5};
        expectOut("fwd_mixed", 4'b1001, 0, 0, 0, 0, 5'd0);

        step();
        exmem_wr_addr = 0; memwb_wr_addr = 0; ex_src = {5'd0, 5'd0};
        expectOut("fwd_r0", 4'b0000, 0, 0, 0, 0, 5'd0);

        step();
        exmem_wr_en = 0; memwb_wr_en = 0; exmem_wr_addr = 5; memwb_wr_addr = 5;
        ex_src = {5'd5, 5'd5};
        expectOut("fwd_disabled", 4'b0000, 0, 0, 0, 0, 5'd0);

        // Load-use on operand 1, then a bubble in EX clears it
        step(); clearIn();
        id_valid = 1; id_src = {5'd7, 5'd2};
        ex_valid = 1; ex_is_load = 1; ex_wr_addr = 7;
        expectOut("loaduse", 4'b0000, 1, 0, 0, 0, 5'd0);

        step();
        ex_valid = 0; ex_is_load = 0; ex_wr_addr = 0;
        expectOut("loaduse_one_cycle", 4'b0000, 0, 0, 0, 0, 5'd0);

        step();
        id_src = {5'd0, 5'd2}; ex_valid = 1; ex_is_load = 1; ex_wr_addr = 0;
        expectOut("loaduse_r0", 4'b0000, 0, 0, 0, 0, 5'd0);

        // Multiply to r9 issued at T with a dependent in ID
        step(); clearIn();
        ex_valid = 1; ex_is_mul = 1; ex_wr_addr = 9;
        id_valid = 1; id_src = {5'd0, 5'd9};
        expectOut("mul_issue", 4'b0000, 0, 0, 0, 0, 5'd0);

        step();
        ex_valid = 0; ex_is_mul = 0; ex_wr_addr = 0;
        expectOut("mul_raw_t1", 4'b0000, 1, 1, 0, 0, 5'd0);

        step();
        expectOut("mul_raw_t2", 4'b0000, 1, 1, 0, 0, 5'd0);

        step();
        expectOut("mul_release_t3", 4'b0000, !FWD, 1, 0, 0, 5'd0);

        step();
        ex_src = {5'd0, 5'd9};
        expectOut("mul_done_t4", FWD ? 4'b0011 : 4'b0000, 0, 1, 1, 1, 5'd9);

        step(); clearIn();
        expectOut("mul_idle_t5", 4'b0000, 0, 0, 0, 0, 5'd0);

        // ex_valid=0 must block issue
        step();
        ex_is_mul = 1; ex_wr_addr = 4;
        step(); clearIn();
        expectOut("mul_blocked", 4'b0000, 0, 0, 0, 0, 5'd0);

        // Back-to-back multiplies, second issued in the first done cycle
        step(); clearIn();
        ex_valid = 1; ex_is_mul = 1; ex_wr_addr = 12;
        step(); clearIn();
        expectOut("b2b_busy_t1", 4'b0000, 0, 1, 0, 0, 5'd0);

        step();
        id_valid = 1; id_is_mul = 1;
        expectOut("struct_stall", 4'b0000, 1, 1, 0, 0, 5'd0);

        step();
        expectOut("struct_release", 4'b0000, !FWD, 1, 0, 0, 5'd0);

        step();
        id_valid = 0; id_is_mul = 0;
        ex_valid = 1; ex_is_mul = 1; ex_wr_addr = 13;
        expectOut("b2b_done1", 4'b0000, 0, 1, 1, 1, 5'd12);

        for (int k = 5; k < 8; k++) begin
            step(); clearIn();
            expectOut($sformatf("b2b_busy_t%0d", k), 4'b0000, 0, 1, 0, 0, 5'd0);
        end

        step();
        expectOut("b2b_done2", 4'b0000, 0, 1, 1, 1, 5'd13);

        step();
        expectOut("b2b_idle", 4'b0000, 0, 0, 0, 0, 5'd0);

        // Reset while a multiply is in flight
        step(); clearIn();
        ex_valid = 1; ex_is_mul = 1; ex_wr_addr = 9;

        step(); clearIn();
        id_valid = 1; id_src = {5'd0, 5'd9};
        expectOut("rst_pre_busy", 4'b0000, 1, 1, 0, 0, 5'd0);

        step();
        rst = 1;
        expectOut("rst_asserted", 4'b0000, 1, 1, 0, 0, 5'd0);

        step();
        rst = 0;
        expectOut("rst_discard", 4'b0000, 0, 0, 0, 1, 5'd0);

        for (int k = 4; k < 6; k++) begin
            step();
            expectOut($sformatf("rst_no_done_t%0d", k), 4'b0000, 0, 0, 0, 0, 5'd0);
        end

        step();
        step();
        if (q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
